// File: rtl/sreg_ser_ctrl.sv
// sreg_ser_ctrl: sequencing controller for a parallel-load shift register
// used as a word serializer.
//
// Upstream side: accepts one N*WIDTH-bit word per valid/ready handshake
// and loads it into the shift register with a single pl pulse.
// Shift side: issues one en pulse per slice. Slice 0 (the least
// significant WIDTH bits) goes out first.
// Downstream side: the register's so output is registered and only
// changes on en. This block keeps a valid/first/last shadow of whatever
// slice so currently holds, and holds off the next en until the consumer
// has taken that slice. A pending slice is therefore never overwritten.
//
// A completed-word counter counts every consumed last slice. It wraps at
// 2**CNTW.

module sreg_ser_ctrl #(
  parameter int               N     = 4,
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] FILL  = '0,
  parameter int               CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  // word source
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  // shift register control
  output logic                 sr_pl,
  output logic                 sr_en,
  output logic [N*WIDTH-1:0]   sr_din,
  output logic [WIDTH-1:0]     sr_si,
  // slice stream framing (data itself comes from the sreg so pin)
  output logic                 so_valid,
  input  logic                 so_ready,
  output logic                 so_first,
  output logic                 so_last,
  // status
  output logic                 busy,
  output logic [CNTW-1:0]      words_done
);

  // Slice index width. Keep at least one bit so that N=1 still has a
  // legal counter. For N=1 the counter stays at zero.
  localparam int              CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_ZERO = '0;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CNTW-1:0] WD_ONE   = CNTW'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]      state_q,      state_d;
  logic [CW-1:0]   cnt_q,        cnt_d;
  logic            so_valid_q,   so_valid_d;
  logic            so_first_q,   so_first_d;
  logic            so_last_q,    so_last_d;
  logic [CNTW-1:0] words_done_q, words_done_d;

  logic in_ready_s;
  logic sr_pl_s;
  logic sr_en_s;
  logic cnt_at_last_s;
  logic so_take_s;

  assign cnt_at_last_s = (cnt_q == LAST_IDX);
  assign so_take_s     = so_valid_q & so_ready;

  // Sequencer: handshake outputs, pl/en strobes and next state/index.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_s = 1'b0;
    sr_pl_s    = 1'b0;
    sr_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Loading with pl does not disturb so. A last slice that is still
        // waiting for the consumer does not block the next load.
        in_ready_s = ~clr;
        sr_pl_s    = in_valid & ~clr;
        if (sr_pl_s) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_SHIFT: begin
        // Only shift once so is free. A slice that is still pending
        // must stay on so until the consumer takes it.
        sr_en_s = ~clr & (~so_valid_q | so_ready);
        if (sr_en_s) begin
          if (cnt_at_last_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_SHIFT;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_SHIFT;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    // Abort overrides everything else. The stale register contents are
    // harmless because the next word reloads them through pl.
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      state_d = state_d;
      cnt_d   = cnt_d;
    end
  end

  // Slice shadow: tracks which slice so holds and whether it is unconsumed.
  always_comb begin
    so_valid_d = so_valid_q;
    so_first_d = so_first_q;
    so_last_d  = so_last_q;
    if (clr) begin
      so_valid_d = 1'b0;
      so_first_d = 1'b0;
      so_last_d  = 1'b0;
    end else if (sr_en_s) begin
      so_valid_d = 1'b1;
      so_first_d = (cnt_q == CNT_ZERO);
      so_last_d  = cnt_at_last_s;
    end else if (so_take_s) begin
      so_valid_d = 1'b0;
      so_first_d = 1'b0;
      so_last_d  = 1'b0;
    end else begin
      so_valid_d = so_valid_q;
      so_first_d = so_first_q;
      so_last_d  = so_last_q;
    end
  end

  // Completed-word counter: counts consumed last slices and wraps.
  always_comb begin
    words_done_d = words_done_q;
    if (~clr & so_take_s & so_last_q) begin
      words_done_d = words_done_q + WD_ONE;
    end else begin
      words_done_d = words_done_q;
    end
  end

  // State, index, slice-shadow and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      so_valid_q   <= 1'b0;
      so_first_q   <= 1'b0;
      so_last_q    <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      so_valid_q   <= so_valid_d;
      so_first_q   <= so_first_d;
      so_last_q    <= so_last_d;
      words_done_q <= words_done_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign sr_pl      = sr_pl_s;
  assign sr_en      = sr_en_s;
  assign sr_din     = in_data;
  assign sr_si      = FILL;
  assign so_valid   = so_valid_q;
  assign so_first   = so_first_q;
  assign so_last    = so_last_q;
  assign busy       = (state_q != ST_IDLE) | so_valid_q;
  assign words_done = words_done_q;

endmodule

// File: doc/sreg_ser_ctrl.md
Name: sreg_ser_ctrl

Overview:
Sequencing controller for the parallel-load shift register (sreg) used as a word serializer. It accepts N*WIDTH-bit words over a valid/ready handshake and drives the shift register's pl/en/din/si. It also tracks each slice as it appears on the register's registered serial output (so) and presents that slice to a downstream consumer as a valid/ready stream with first/last framing. It sits between a word source and the sreg instance and shares clk/rstn with it.

Parameters:
N, 4, slices per word (>=1); must equal sreg n
WIDTH, 1, bits per slice; must equal sreg width
FILL, 0, constant driven on sr_si (WIDTH bits, replicated/truncated)
CNTW, 16, width of completed-word counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
clr  in  1  synchronous abort: return to IDLE, drop pending slice
in_valid  in  1  word available
in_ready  out  1  controller can accept word this cycle
in_data  in  N*WIDTH  word; slice 0 = bits [WIDTH-1:0], sent first
sr_pl  out  1  to sreg pl
sr_en  out  1  to sreg en
sr_din  out  N*WIDTH  to sreg din (= in_data)
sr_si  out  WIDTH  to sreg si (= FILL)
so_valid  out  1  sreg so holds an unconsumed slice
so_ready  in  1  consumer takes slice this cycle
so_first  out  1  current slice is slice 0
so_last  out  1  current slice is slice N-1
busy  out  1  state != IDLE or so_valid
words_done  out  CNTW  count of last slices consumed, wraps

Behaviour:
- Reset (rstn low, async): state=IDLE, cnt=0, so_valid=0, so_first=0, so_last=0, words_done=0. sr_pl/sr_en are combinational from state, so they are 0 in reset.
- States: IDLE, SHIFT. cnt is ceil(log2(N))-bit (min 1) and holds the index of the next slice to shift.
- IDLE: in_ready=1 (ignores so_valid, since pl does not disturb so). sr_pl = in_valid & ~clr. On accept, go to SHIFT with cnt=0. sr_en=0.
- SHIFT: in_ready=0, sr_pl=0. sr_en = ~clr & (~so_valid | so_ready).
  - On sr_en: cnt++.
  - On sr_en with cnt==N-1: go to IDLE, cnt=0.
- Slice flags, registered: on sr_en, so_valid<=1, so_first<=(cnt==0), so_last<=(cnt==N-1). Else if so_valid & so_ready, so_valid<=0 and so_first/so_last<=0.
- words_done increments when so_valid & so_ready & so_last.
- Latency: word accepted at cycle t; sr_pl at t; first sr_en at t+1; slice 0 valid at t+2.
- Throughput: N+1 cycles per word with so_ready held high. While the last slice is pending, the next word may load in IDLE. The next word's first sr_en waits for that last slice to be consumed.
- Backpressure: so_ready low with so_valid high → sr_en=0. The slice is held stable (sreg so only updates on en).
- N=1: a single en per word; so_first and so_last are both 1.
- clr (sync, highest priority over handshakes): state=IDLE, cnt=0, so_valid/first/last=0, words_done unchanged. sr_pl=sr_en=0 that cycle. Stale sreg contents are harmless because the next word reloads via pl.
- Async reset mid-word: everything returns to reset values immediately. The sreg (same rstn) clears too.
- sr_din always equals in_data; sr_si always equals FILL.

Test Plan:
- Reset: rstn low mid-SHIFT → so_valid=0, in_ready=1, words_done=0, sr_en=0 immediately.
- Basic: N=4, WIDTH=8, in_data=0x44332211, so_ready=1 → so shows 11,22,33,44 on cycles t+2..t+5. so_first only on 11, so_last only on 44, words_done=1.
- Back-to-back: two words 0x44332211 and 0x88776655, in_valid held, so_ready=1 → eight consecutive slices 11..44 then 55..88 with a one-cycle bubble for pl. in_ready asserted only in IDLE cycles.
- Backpressure: so_ready low for 3 cycles while slice 22 is valid → sr_en=0, so stays 22, cnt stays 2. Release → 33 follows next cycle; no slice is lost or duplicated.
- Last-slice overlap: so_ready low while slice 44 is valid; second word offered → accepted (sr_pl=1) and 44 is held. First en for the new word occurs only in the cycle so_ready=1.
- clr during SHIFT at cnt=2 → next cycle IDLE, so_valid=0, words_done unchanged. A new word 0xDDCCBBAA then serializes AA,BB,CC,DD correctly.
